// File: rtl/pipeline_latealu_pkg.sv
// Shared definitions for the late ALU stage: opcodes, multiplier FSM states, iteration count.
// Opcode 000111 (multu) is only decoded when LATEALU_MULTU_EN is defined.
package pipeline_latealu_pkg;

  localparam logic [5:0] LATEALU_OP_SRL   = 6'b000010;
  localparam logic [5:0] LATEALU_OP_SRA   = 6'b000011;
  localparam logic [5:0] LATEALU_OP_MULT  = 6'b000100;
  localparam logic [5:0] LATEALU_OP_MTHI  = 6'b000101;
  localparam logic [5:0] LATEALU_OP_MTLO  = 6'b000110;
  localparam logic [5:0] LATEALU_OP_MULTU = 6'b000111;

  localparam int unsigned LATEALU_MUL_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd2
  } latealu_state_e;

  // Magnitude of a two's-complement word; the most negative value maps onto itself as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    logic [31:0] r;
    if (v[31]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipeline_latealu_if.sv
// ALU <-> late ALU hand-off bus: op request from the ALU, shift result and HI/LO back.
interface pipeline_latealu_if;
  logic        latealu_enable;
  logic [5:0]  latealu_op;
  logic [31:0] latealu_a0;
  logic [31:0] latealu_a1;
  logic [31:0] shift_result;
  logic        result_valid;
  logic [31:0] latealu_mult_hi;
  logic [31:0] latealu_mult_lo;
  logic        busy;
  logic        op_error;

  modport master (
    output latealu_enable, latealu_op, latealu_a0, latealu_a1,
    input  shift_result, result_valid, latealu_mult_hi, latealu_mult_lo, busy, op_error
  );

  modport slave (
    input  latealu_enable, latealu_op, latealu_a0, latealu_a1,
    output shift_result, result_valid, latealu_mult_hi, latealu_mult_lo, busy, op_error
  );
endinterface

// File: rtl/pipeline_latealu_mult.sv
// Iterative shift-add 32x32 multiplier: 32 MUL iterations, then one FIX cycle applying the sign.
// done pulses during FIX with the final 64-bit product on product.
module latealu_seq_mult
  import pipeline_latealu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [63:0] product
);

  localparam logic [5:0] LAST_ITER = 6'(LATEALU_MUL_ITERS - 1);

  latealu_state_e state_r;
  latealu_state_e state_s;
  logic [63:0]    mcand_r;
  logic [31:0]    mplier_r;
  logic [63:0]    acc_r;
  logic [5:0]     cnt_r;
  logic           sign_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_MUL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_r == LAST_ITER) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_MUL;
        end
      end
      ST_FIX:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: product is the sign-corrected accumulator, qualified by done
  always_comb begin
    done    = 1'b0;
    product = acc_r;
    case (state_r)
      ST_FIX: begin
        done = 1'b1;
        if (sign_r) begin
          product = ~acc_r + 64'd1;
        end else begin
          product = acc_r;
        end
      end
      default: begin
        done    = 1'b0;
        product = acc_r;
      end
    endcase
  end

  // Shift-add datapath: operands latched on start, one partial product per MUL cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_r  <= 64'd0;
      mplier_r <= 32'd0;
      acc_r    <= 64'd0;
      cnt_r    <= 6'd0;
      sign_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (is_signed) begin
              mcand_r  <= {32'd0, mag32(a)};
              mplier_r <= mag32(b);
              sign_r   <= a[31] ^ b[31];
            end else begin
              mcand_r  <= {32'd0, a};
              mplier_r <= b;
              sign_r   <= 1'b0;
            end
            acc_r <= 64'd0;
            cnt_r <= 6'd0;
          end
        end
        ST_MUL: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= {mcand_r[62:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[31:1]};
          cnt_r    <= cnt_r + 6'd1;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_latealu.sv
// Late ALU stage: srl/sra shifter, HI/LO registers, mult via latealu_seq_mult, busy/op_error.
// Optional unsigned multiply (op 000111) is enabled by defining LATEALU_MULTU_EN.
module pipeline_latealu
  import pipeline_latealu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  pipeline_latealu_if.slave   alu
);

  logic        is_srl_s, is_sra_s, is_mul_s, mul_signed_s;
  logic        is_mthi_s, is_mtlo_s, unknown_s;
  logic        start_s, err_s, done_s;
  logic [63:0] product_s;
  logic [4:0]  amt_s;
  logic [31:0] srl_val_s, sra_val_s;

  logic [31:0] shift_result_r;
  logic        result_valid_r;
  logic [31:0] hi_r, lo_r;
  logic        busy_r;
  logic        op_error_r;

  // Opcode decode
  always_comb begin
    is_srl_s     = 1'b0;
    is_sra_s     = 1'b0;
    is_mul_s     = 1'b0;
    mul_signed_s = 1'b1;
    is_mthi_s    = 1'b0;
    is_mtlo_s    = 1'b0;
    unknown_s    = 1'b0;
    case (alu.latealu_op)
      LATEALU_OP_SRL:  is_srl_s  = 1'b1;
      LATEALU_OP_SRA:  is_sra_s  = 1'b1;
      LATEALU_OP_MULT: is_mul_s  = 1'b1;
      LATEALU_OP_MTHI: is_mthi_s = 1'b1;
      LATEALU_OP_MTLO: is_mtlo_s = 1'b1;
`ifdef LATEALU_MULTU_EN
      LATEALU_OP_MULTU: begin
        is_mul_s     = 1'b1;
        mul_signed_s = 1'b0;
      end
`endif
      default: unknown_s = 1'b1;
    endcase
  end

  // HI/LO-touching ops are refused while a multiply is in flight
  assign start_s = alu.latealu_enable & is_mul_s & ~busy_r;
  assign err_s   = alu.latealu_enable &
                   (unknown_s | ((is_mul_s | is_mthi_s | is_mtlo_s) & busy_r));

  // Both shift flavours; kept as separate statements so >>> stays arithmetic
  always_comb begin
    amt_s     = alu.latealu_a1[4:0];
    srl_val_s = alu.latealu_a0 >> amt_s;
    sra_val_s = 32'($signed(alu.latealu_a0) >>> amt_s);
  end

  latealu_seq_mult u_mult (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s),
    .is_signed (mul_signed_s),
    .a         (alu.latealu_a0),
    .b         (alu.latealu_a1),
    .done      (done_s),
    .product   (product_s)
  );

  // Shifter output register; result holds until the next shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_result_r <= 32'd0;
      result_valid_r <= 1'b0;
    end else begin
      result_valid_r <= alu.latealu_enable & (is_srl_s | is_sra_s);
      if (alu.latealu_enable & is_srl_s) begin
        shift_result_r <= srl_val_s;
      end else if (alu.latealu_enable & is_sra_s) begin
        shift_result_r <= sra_val_s;
      end else begin
        shift_result_r <= shift_result_r;
      end
    end
  end

  // HI/LO: multiply writeback at FIX, otherwise mthi/mtlo when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (done_s) begin
      hi_r <= product_s[63:32];
      lo_r <= product_s[31:0];
    end else begin
      if (alu.latealu_enable & is_mthi_s & ~busy_r) begin
        hi_r <= alu.latealu_a0;
      end
      if (alu.latealu_enable & is_mtlo_s & ~busy_r) begin
        lo_r <= alu.latealu_a0;
      end
    end
  end

  // busy spans accept edge to FIX edge; op_error is a one-cycle pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r     <= 1'b0;
      op_error_r <= 1'b0;
    end else begin
      op_error_r <= err_s;
      if (start_s) begin
        busy_r <= 1'b1;
      end else if (done_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  assign alu.shift_result    = shift_result_r;
  assign alu.result_valid    = result_valid_r;
  assign alu.latealu_mult_hi = hi_r;
  assign alu.latealu_mult_lo = lo_r;
  assign alu.busy            = busy_r;
  assign alu.op_error        = op_error_r;

endmodule

// File: doc/pipeline_latealu.md
# pipeline_latealu

Late ALU stage sitting directly downstream of the pipeline ALU. It executes the operations the ALU hands off through its `latealu_*` outputs: logical/arithmetic right shifts, signed 32×32 multiply, and `mthi`/`mtlo`. It owns the HI/LO architectural registers and feeds them back to the ALU for `mfhi`/`mflo`. The multiply is an iterative shift-add unit, so the block exposes a `busy` flag that the hazard logic uses to stall.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  pipeline clock; all state on rising edge
- `rst`  in  1  reset, **asynchronous, active-low** (0 = reset)
- `latealu_enable`  in  1  op valid this cycle (from ALU, registered there)
- `latealu_op`  in  6  opcode: 000010 srl, 000011 sra, 000100 mult, 000101 mthi, 000110 mtlo
- `latealu_a0`  in  32  shift operand / multiplicand / mthi-mtlo value
- `latealu_a1`  in  32  shift amount in bits [4:0] (upper bits ignored) / multiplier
- `shift_result`  out  32  registered shift result
- `result_valid`  out  1  one-cycle pulse: `shift_result` valid
- `latealu_mult_hi`  out  32  HI register
- `latealu_mult_lo`  out  32  LO register
- `busy`  out  1  multiply in progress; HI/LO not yet final
- `op_error`  out  1  one-cycle pulse: unknown op, or HI/LO op rejected while busy

## Operation
- FSM states: IDLE, MUL, FIX.
- **IDLE, mult accepted:**
  - Latch the magnitudes |a0|, |a1| as 32-bit unsigned; |0x80000000| = 0x80000000.
  - Latch the result sign, a0[31]^a1[31].
  - Clear the 64-bit accumulator and the 6-bit counter; go to MUL.
- **MUL:**
  - Each cycle: if the multiplier LSB is 1, add the multiplicand (64-bit, pre-shifted) into the accumulator.
  - Shift the multiplicand left and the multiplier right; increment the counter.
  - After the 32nd iteration go to FIX.
- **FIX:**
  - Two's-complement negate the 64-bit accumulator if the sign is set.
  - Write HI=[63:32], LO=[31:0]; go to IDLE.
- HI/LO keep their previous values throughout MUL/FIX; they update only at the FIX edge.
- **srl/sra:**
  - `shift_result` = a0 >> a1[4:0], logical or arithmetic respectively.
  - Executes in any state; the shifter is independent of the multiplier.
- **mthi/mtlo in IDLE:** write a0 to HI or LO.
- **mult/mthi/mtlo while busy (MUL/FIX):** ignored, `op_error` pulses, no state change.
- **Unknown op with enable:** `op_error` pulses, no state change.
- `latealu_enable`=0: inputs ignored.
- **Reset (rst=0), including mid-multiply:**
  - All outputs 0, HI=LO=0, FSM IDLE, counter and accumulator cleared.
  - Takes effect immediately (asynchronous).

## Timing
- Shifts: enable sampled at edge E → `shift_result` and `result_valid` valid after E, for one cycle. `shift_result` holds its value until the next shift.
- Multiply: accepted at edge E0 → `busy`=1 after E0.
  - Iterations occur at E1..E32; FIX completes at E33.
  - HI/LO final and `busy`=0 after E33. `busy` is high for exactly 33 cycles.
- mthi/mtlo: HI/LO updated after the accepting edge (1-cycle latency), visible combinationally to the ALU's next `mfhi`/`mflo`.
- Upstream contract: the hazard unit stalls `mfhi`/`mflo`/`mult`/`mthi`/`mtlo` while `busy`=1. The rejection path is a safety net only.
- A shift and the FIX write can occur in the same cycle; both take effect.

## Configuration
- Macro: `LATEALU_MULTU_EN`.
- **Defined:** adds op 000111 `multu`. Same FSM and latency, but the operands are taken as unsigned (no magnitude conversion, sign forced 0).
- **Undefined:** op 000111 is an unknown op and pulses `op_error`.

## Structure
- Shared package `pipeline_latealu_pkg`:
  - opcode constants (`LATEALU_OP_SRL`, `_SRA`, `_MULT`, `_MTHI`, `_MTLO`, `_MULTU`)
  - FSM state typedef
  - iteration count constant (32)
- One sub-module, `latealu_seq_mult`:
  - Holds the MUL/FIX datapath, counter and start/done handshake.
  - Interface: `start`, `is_signed`, a, b in; `done` pulse, 64-bit product out.
  - The top level holds the shifter, HI/LO, error logic and `busy`.

## Test plan
1. srl, a0=0x80000000, a1=4 → `shift_result`=0x08000000 with `result_valid` high for exactly 1 cycle; sra with the same operands → 0xF8000000.
2. mult a0=0xFFFFFFFD (−3), a1=7 → `busy` high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB. HI/LO unchanged while busy.
3. mult a0=a1=0x80000000 → HI=0x40000000, LO=0x00000000. mult 0×0x12345678 → HI=LO=0.
4. mthi a0=0x1234 in IDLE → HI=0x1234 next cycle. mtlo issued in MUL → `op_error` pulse, LO unchanged, multiply result still correct.
5. Reset asserted at cycle 10 of a multiply → `busy`, HI, LO = 0 immediately. A new mult after release completes normally.
6. With `LATEALU_MULTU_EN`: multu 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE. Without it: op 000111 → `op_error` pulse, HI/LO unchanged.
